lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
CPU-side load/store initiator. It drives requests into the 14-bit byte-addressed data memory wrapper through the enable/write/byte_enable/busy interface. It accepts one load or store from the execute stage, generates byte enables and lane-replicated store data, and issues a single memory request. It waits for the memory to go idle, then returns extracted and extended load data or a store-done response to writeback.

Parameters:
ADDR_WIDTH, 14, width of mem_addr; request addresses with bits [31:ADDR_WIDTH] set fault.
TIMEOUT, 64, max cycles in WAIT before a timeout error (range 2..255).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store source (rs2)
resp_valid  out  1  one-cycle pulse, response valid
resp_data  out  32  load result; 0 for stores and errors
resp_error  out  2  00 ok, 01 misaligned, 10 access fault, 11 timeout
mem_enable  out  1  request strobe to memory
mem_write  out  1  request is a write
mem_addr  out  ADDR_WIDTH  byte address to memory
mem_byte_enable  out  4  lane mask, bit n = byte n
mem_wdata  out  32  lane-aligned store data
mem_rdata  in  32  memory read data, valid when mem_busy falls after a read
mem_busy  in  1  memory busy

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_error=00. All mem_* outputs are 0. Timeout counter=0.
- Reset asserted in any state aborts the operation with no response. mem_enable drops immediately.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE on accept when the request is legal. The op, funct3, addr[1:0] and wdata are registered.
- IDLE -> RESP on accept when the request is illegal. No mem_enable is issued. resp_error is 01 or 10; misaligned has priority over fault.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00.
- Fault: req_addr[31:ADDR_WIDTH]!=0, or funct3 is not one of the five listed codes (stores accept only 000/001/010).
- ISSUE, exactly one cycle: mem_enable=1, mem_write=req_write, mem_addr=req_addr[ADDR_WIDTH-1:0].
- Byte enables: B/BU 0001<<addr[1:0]; H/HU 0011<<(2*addr[1]); W 1111. Held stable through WAIT.
- Store data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
- Next state is WAIT. mem_enable is 0 in WAIT.
- WAIT: the first WAIT cycle never completes, because the memory raises busy one half-cycle after enable.
- From the second WAIT cycle on, mem_busy=0 -> RESP, and mem_rdata is captured on that edge.
- The counter increments each WAIT cycle. At count==TIMEOUT with busy still 1 -> RESP with error 11, no data captured.
- RESP, one cycle: resp_valid=1. Then -> IDLE and resp_valid returns to 0.
- Load extraction: shift = 8*addr[1:0].
  - B: sign-extend byte. BU: zero-extend byte.
  - H: sign-extend halfword. HU: zero-extend halfword.
  - W: rdata unchanged.
- Stores: resp_data=0.
- Latency for a legal op with busy low at the second WAIT cycle: accept edge N, mem_enable in cycle N+1, resp_valid in cycle N+4. Illegal op: resp_valid in cycle N+1.
- req_valid while not IDLE is ignored: req_ready=0, no queueing.
- req_valid may drop after accept without effect. resp_data and resp_error hold their value until the next RESP.

Test Plan:
- Load word: memory preloaded at 0x0010 = 0xDEADBEEF; LW 0x10 -> one mem_enable pulse, byte_enable 1111, write=0; resp_valid 4 cycles after accept; resp_data 0xDEADBEEF; error 00.
- Byte/halfword loads on the same word: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- Stores: SB 0x21 wdata 0x123456AB -> byte_enable 0010, mem_wdata 0xABABABAB. SH 0x22 -> byte_enable 1100, mem_wdata 0x56AB56AB. Readback LW 0x20 shows only the written lanes changed.
- Illegal ops: LH 0x11 -> error 01 at cycle N+1, no mem_enable. SW 0x00004000 with ADDR_WIDTH=14 -> error 10. LW 0x4001 -> error 01 (misaligned has priority).
- Busy stall and timeout: hold mem_busy=1 for 10 cycles -> resp_valid exactly one cycle after busy falls. With TIMEOUT=8 and busy stuck at 1 -> error 11 after 8 WAIT cycles, then req_ready=1.
- Reset mid-op: assert reset=0 during WAIT, between clock edges -> mem_enable, resp_valid and mem_byte_enable go to 0 immediately; no response is produced; after release a new LW completes normally.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_mem_initiator: single-outstanding load/store initiator that drives   |
// | the enable/write/byte_enable/busy data-memory interface.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsu_mem_initiator #(
  parameter int ADDR_WIDTH = 14,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic [1:0]            resp_error,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_byte_enable,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        op_write;
  logic [2:0]  op_funct3;
  logic [1:0]  op_lo;
  logic [7:0]  wait_cnt;

  logic        f3_legal;
  logic        misaligned;
  logic        fault;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  assign req_ready = (state == S_IDLE);

  always_comb begin
    f3_legal   = 1'b0;
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_write;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = (((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr[0]) ||
                 ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    fault      = (req_addr[31:ADDR_WIDTH] != '0) || !f3_legal;
    case (req_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then sign/zero extend by funct3.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  lo,
                                               input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> {lo, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{s[7]}}, s[7:0]};
      3'b100:  load_extract = {24'd0, s[7:0]};
      3'b001:  load_extract = {{16{s[15]}}, s[15:0]};
      3'b101:  load_extract = {16'd0, s[15:0]};
      default: load_extract = rd;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      op_write        <= 1'b0;
      op_funct3       <= 3'b000;
      op_lo           <= 2'b00;
      wait_cnt        <= 8'd0;
      resp_valid      <= 1'b0;
      resp_data       <= 32'd0;
      resp_error      <= 2'b00;
      mem_enable      <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= '0;
      mem_byte_enable <= 4'b0000;
      mem_wdata       <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_write  <= req_write;
            op_funct3 <= req_funct3;
            op_lo     <= req_addr[1:0];
            if (misaligned || fault) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_data  <= 32'd0;
              resp_error <= misaligned ? 2'b01 : 2'b10;
            end else begin
              state           <= S_ISSUE;
              mem_enable      <= 1'b1;
              mem_write       <= req_write;
              mem_addr        <= req_addr[ADDR_WIDTH-1:0];
              mem_byte_enable <= be_next;
              mem_wdata       <= req_write ? wdata_next : 32'd0;
            end
          end
        end
        S_ISSUE: begin
          mem_enable <= 1'b0;
          mem_write  <= 1'b0;
          wait_cnt   <= 8'd0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // Busy is not yet visible in the first WAIT cycle, so it cannot complete.
          if ((wait_cnt != 8'd0) && !mem_busy) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_error <= 2'b00;
            resp_data  <= op_write ? 32'd0 : load_extract(op_funct3, op_lo, mem_rdata);
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_error <= 2'b11;
            resp_data  <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RESP: begin
          wait_cnt <= 8'd0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// Directed bench for lsu_mem_initiator with a behavioural byte-lane memory;
// a second instance with TIMEOUT=8 and busy stuck high covers the timeout path.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_busy;
  logic [31:0] mem_rdata;

  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_error;
  logic        mem_enable;
  logic        mem_write;
  logic [13:0] mem_addr;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;

  logic        t_req_valid;
  logic        t_req_ready;
  logic        t_resp_valid;
  logic [31:0] t_resp_data;
  logic [1:0]  t_resp_error;
  logic        t_mem_enable;
  logic        t_mem_write;
  logic [13:0] t_mem_addr;
  logic [3:0]  t_mem_byte_enable;
  logic [31:0] t_mem_wdata;

  int checks = 0;
  int errors = 0;
  int stall  = 0;
  int busy_cnt;
  int lat, ens, busy_hi, t_lat, quiet;
  logic [3:0]  seen_be;
  logic [31:0] seen_wd;
  logic        seen_wr;
  logic [13:0] seen_addr;
  logic [31:0] mem [0:4095];
  logic [11:0] widx;

  lsu_mem_initiator #(.ADDR_WIDTH(14), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  lsu_mem_initiator #(.ADDR_WIDTH(14), .TIMEOUT(8)) dut_t (
    .clk(clk), .reset(reset),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(t_resp_valid), .resp_data(t_resp_data), .resp_error(t_resp_error),
    .mem_enable(t_mem_enable), .mem_write(t_mem_write), .mem_addr(t_mem_addr),
    .mem_byte_enable(t_mem_byte_enable), .mem_wdata(t_mem_wdata),
    .mem_rdata(32'h0), .mem_busy(1'b1)
  );

  always #5 clk = ~clk;

  // Memory acts on the enable cycle; busy then rises at following falling edges for 'stall' cycles.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt  = 0;
      mem_busy  = 1'b0;
      mem_rdata = 32'h0;
      mem[4]    = 32'hDEADBEEF;
      mem[8]    = 32'h11223344;
    end else if (mem_enable) begin
      widx = mem_addr[13:2];
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byte_enable[b]) mem[widx][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata = mem[widx];
      end
      busy_cnt = stall;
    end else begin
      mem_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    @(negedge clk);
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; ens = 0; busy_hi = 0;
    seen_be = 4'h0; seen_wd = 32'h0; seen_wr = 1'b0; seen_addr = 14'h0;
    for (int i = 1; i <= 200; i++) begin
      if (mem_enable) begin
        ens++; seen_be = mem_byte_enable; seen_wd = mem_wdata;
        seen_wr = mem_write; seen_addr = mem_addr;
      end
      if (mem_busy) busy_hi++;
      if (resp_valid) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; t_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp", {resp_data[31:3], resp_error, resp_valid}, 32'd0);
    check("rst_mem", {mem_enable, mem_write, mem_byte_enable, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_t_ready", {31'd0, t_req_ready}, 32'd1);
    @(negedge clk); reset = 1'b1;

    run_op(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_latency", lat, 32'd4);
    check("lw_enables", ens, 32'd1);
    check("lw_be_wr", {seen_wr, seen_be}, 32'h0F);
    check("lw_addr", {18'd0, seen_addr}, 32'h10);
    check("lw_data", resp_data, 32'hDEADBEEF);
    check("lw_err", {30'd0, resp_error}, 32'd0);
    @(posedge clk); #1;
    check("lw_pulse_one", {30'd0, resp_valid, req_ready}, 32'd1);
    check("lw_data_hold", resp_data, 32'hDEADBEEF);

    run_op(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_data", resp_data, 32'hFFFFFFDE);
    run_op(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_data", resp_data, 32'h000000DE);
    run_op(1'b0, 3'b001, 32'h12, 32'h0);
    check("lh_data", resp_data, 32'hFFFFDEAD);
    run_op(1'b0, 3'b101, 32'h10, 32'h0);
    check("lhu_data", resp_data, 32'h0000BEEF);
    check("lhu_be", {28'd0, seen_be}, 32'h3);

    run_op(1'b1, 3'b000, 32'h21, 32'h123456AB);
    check("sb_be_wr", {seen_wr, seen_be}, 32'h12);
    check("sb_wdata", seen_wd, 32'hABABABAB);
    check("sb_resp", {resp_data[31:2], resp_error}, 32'd0);
    check("sb_latency", lat, 32'd4);
    run_op(1'b1, 3'b001, 32'h22, 32'h123456AB);
    check("sh_be", {28'd0, seen_be}, 32'hC);
    check("sh_wdata", seen_wd, 32'h56AB56AB);
    run_op(1'b0, 3'b010, 32'h20, 32'h0);
    check("readback", resp_data, 32'h56ABAB44);

    run_op(1'b0, 3'b001, 32'h11, 32'h0);
    check("lh_mis_err", {30'd0, resp_error}, 32'd1);
    check("lh_mis_lat", lat, 32'd1);
    check("lh_mis_noen", ens, 32'd0);
    check("lh_mis_data", resp_data, 32'd0);
    run_op(1'b1, 3'b010, 32'h00004000, 32'hCAFEF00D);
    check("sw_fault_err", {30'd0, resp_error}, 32'd2);
    check("sw_fault_noen", ens, 32'd0);
    run_op(1'b0, 3'b010, 32'h00004001, 32'h0);
    check("mis_prio_err", {30'd0, resp_error}, 32'd1);
    run_op(1'b1, 3'b100, 32'h10, 32'h0);
    check("sbu_fault_err", {30'd0, resp_error}, 32'd2);
    run_op(1'b0, 3'b011, 32'h10, 32'h0);
    check("f3_fault_err", {30'd0, resp_error}, 32'd2);
    check("f3_fault_lat", lat, 32'd1);

    stall = 10;
    run_op(1'b0, 3'b010, 32'h10, 32'h0);
    check("stall_busy_cycles", busy_hi, 32'd10);
    check("stall_latency", lat, 32'd13);
    check("stall_data", resp_data, 32'hDEADBEEF);
    check("stall_err", {30'd0, resp_error}, 32'd0);
    stall = 0;

    @(negedge clk);
    t_req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    t_lat = 0;
    for (int i = 1; i <= 100; i++) begin
      if (t_resp_valid) begin
        t_lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    check("to_latency", t_lat, 32'd10);
    check("to_err", {30'd0, t_resp_error}, 32'd3);
    check("to_data", t_resp_data, 32'd0);
    @(posedge clk); #1;
    check("to_ready", {31'd0, t_req_ready}, 32'd1);

    stall = 20;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_en", {31'd0, mem_enable}, 32'd0);
    check("mid_rst_resp_be", {27'd0, resp_valid, mem_byte_enable}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); reset = 1'b1;
    stall = 0;
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (resp_valid) quiet++;
    end
    check("mid_rst_no_resp", quiet, 32'd0);
    run_op(1'b0, 3'b010, 32'h10, 32'h0);
    check("post_rst_lat", lat, 32'd4);
    check("post_rst_data", resp_data, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
